// File: rtl/vx_gpr_read_arbiter.sv
// Round-robin arbiter sharing one GPR bank read port between NUM_REQS requesters.
// Each read has one-cycle RAM latency, merges a same-cycle writeback, and lands in a 2-deep response queue.
module vx_gpr_read_arbiter #(
  parameter int NUM_REQS    = 4,
  parameter int ADDRW       = 8,
  parameter int NUM_THREADS = 4,
  parameter int XLEN        = 32,
  parameter int TAGW        = 4,
  localparam int IDXW       = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
  localparam int DATAW      = NUM_THREADS * XLEN
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQS-1:0]       req_valid,
  input  logic [NUM_REQS*ADDRW-1:0] req_addr,
  input  logic [NUM_REQS*TAGW-1:0]  req_tag,
  output logic [NUM_REQS-1:0]       req_ready,
  output logic                      ram_read,
  output logic [ADDRW-1:0]          ram_raddr,
  input  logic [DATAW-1:0]          ram_rdata,
  input  logic                      wb_valid,
  input  logic [ADDRW-1:0]          wb_addr,
  input  logic [NUM_THREADS-1:0]    wb_tmask,
  input  logic [DATAW-1:0]          wb_data,
  output logic                      rsp_valid,
  output logic [IDXW-1:0]           rsp_idx,
  output logic [TAGW-1:0]           rsp_tag,
  output logic [DATAW-1:0]          rsp_data,
  input  logic                      rsp_ready
);

  logic [IDXW-1:0]        rr_ptr_q, rr_ptr_d;
  logic                   inflight_q;
  logic [IDXW-1:0]        inf_idx_q;
  logic [TAGW-1:0]        inf_tag_q;
  logic                   hit_q;
  logic [NUM_THREADS-1:0] hit_mask_q;
  logic [DATAW-1:0]       hit_data_q;

  logic [IDXW-1:0]        q_idx_q  [2];
  logic [TAGW-1:0]        q_tag_q  [2];
  logic [DATAW-1:0]       q_data_q [2];
  logic                   wr_ptr_q, rd_ptr_q;
  logic [1:0]             q_count_q, q_count_d;

  logic                   grant_valid;
  logic [IDXW-1:0]        grant_idx;
  logic [ADDRW-1:0]       grant_addr;
  logic [TAGW-1:0]        grant_tag;
  logic                   wb_hit;
  logic                   rsp_fire;
  logic [2:0]             occ_net;
  logic [DATAW-1:0]       merged_data;

  function automatic logic [IDXW-1:0] wrapIdx(input int v);
    return IDXW'(v % NUM_REQS);
  endfunction

  assign rsp_valid = reset_n & (q_count_q != 2'd0);
  assign rsp_fire  = rsp_valid & rsp_ready;
  assign rsp_idx   = q_idx_q[rd_ptr_q];
  assign rsp_tag   = q_tag_q[rd_ptr_q];
  assign rsp_data  = q_data_q[rd_ptr_q];

  // Outstanding work (in flight plus queued) minus this cycle's pop must leave room for one more.
  assign occ_net = 3'(inflight_q) + 3'(q_count_q) - 3'(rsp_fire);

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = rr_ptr_q;
    for (int k = 0; k < NUM_REQS; k++) begin
      if (!grant_valid && req_valid[wrapIdx(int'(rr_ptr_q) + k)]) begin
        grant_valid = 1'b1;
        grant_idx   = wrapIdx(int'(rr_ptr_q) + k);
      end
    end
    if (!reset_n || occ_net >= 3'd2) begin
      grant_valid = 1'b0;
    end
  end

  assign grant_addr = req_addr[grant_idx*ADDRW +: ADDRW];
  assign grant_tag  = req_tag[grant_idx*TAGW +: TAGW];
  assign wb_hit     = wb_valid && (wb_addr == grant_addr);

  always_comb begin
    req_ready = '0;
    if (grant_valid) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  assign ram_read  = grant_valid;
  assign ram_raddr = grant_valid ? grant_addr : '0;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_valid) begin
      rr_ptr_d = (grant_idx == IDXW'(NUM_REQS - 1)) ? '0 : grant_idx + IDXW'(1);
    end
  end

  // The RAM returns stale lanes for a write landing on the read edge; patch them from the captured writeback.
  always_comb begin
    merged_data = ram_rdata;
    if (hit_q) begin
      for (int j = 0; j < NUM_THREADS; j++) begin
        if (hit_mask_q[j]) begin
          merged_data[j*XLEN +: XLEN] = hit_data_q[j*XLEN +: XLEN];
        end
      end
    end
  end

  always_comb begin
    case ({inflight_q, rsp_fire})
      2'b10:   q_count_d = q_count_q + 2'd1;
      2'b01:   q_count_d = q_count_q - 2'd1;
      default: q_count_d = q_count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rr_ptr_q   <= '0;
      inflight_q <= 1'b0;
      hit_q      <= 1'b0;
      q_count_q  <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      inflight_q <= grant_valid;
      q_count_q  <= q_count_d;
      if (grant_valid) begin
        inf_idx_q  <= grant_idx;
        inf_tag_q  <= grant_tag;
        hit_q      <= wb_hit;
        hit_mask_q <= wb_tmask;
        hit_data_q <= wb_data;
      end
      if (inflight_q) begin
        q_idx_q[wr_ptr_q]  <= inf_idx_q;
        q_tag_q[wr_ptr_q]  <= inf_tag_q;
        q_data_q[wr_ptr_q] <= merged_data;
        wr_ptr_q           <= ~wr_ptr_q;
      end
      if (rsp_fire) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

endmodule

// File: tb/tb_vx_gpr_read_arbiter.sv
// Scoreboard bench for vx_gpr_read_arbiter: a behavioural RAM, a grant/response model
// driven from the stimulus process, and an independent monitor that pops and compares responses.
module tb_vx_gpr_read_arbiter;
  localparam int N  = 4;
  localparam int AW = 8;
  localparam int NT = 4;
  localparam int XL = 32;
  localparam int TW = 4;
  localparam int DW = NT * XL;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*TW-1:0] req_tag = '0;
  logic [N-1:0]    req_ready;
  logic            ram_read;
  logic [AW-1:0]   ram_raddr;
  logic [DW-1:0]   ram_rdata = '0;
  logic            wb_valid = 1'b0;
  logic [AW-1:0]   wb_addr = '0;
  logic [NT-1:0]   wb_tmask = '0;
  logic [DW-1:0]   wb_data = '0;
  logic            rsp_valid;
  logic [IW-1:0]   rsp_idx;
  logic [TW-1:0]   rsp_tag;
  logic [DW-1:0]   rsp_data;
  logic            rsp_ready = 1'b0;

  vx_gpr_read_arbiter #(.NUM_REQS(N), .ADDRW(AW), .NUM_THREADS(NT), .XLEN(XL), .TAGW(TW)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_addr(req_addr), .req_tag(req_tag), .req_ready(req_ready),
    .ram_read(ram_read), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_tmask(wb_tmask), .wb_data(wb_data),
    .rsp_valid(rsp_valid), .rsp_idx(rsp_idx), .rsp_tag(rsp_tag), .rsp_data(rsp_data),
    .rsp_ready(rsp_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            idx;
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
    int            cyc;
  } expT;

  expT           expQ[$];
  logic [DW-1:0] ramMem [256];
  logic [DW-1:0] ramTmp;
  int            testsRun = 0;
  int            testsFailed = 0;
  int            cycle = 0;
  int            rrPtr = 0;

  logic [N-1:0]  nxValid;
  logic [AW-1:0] nxAddr [N];
  logic [TW-1:0] nxTag [N];
  logic          nxWbValid;
  logic [AW-1:0] nxWbAddr;
  logic [NT-1:0] nxWbMask;
  logic [DW-1:0] nxWbData;
  logic          nxRspReady;
  logic          nxReset;

  // Behavioural RAM: read-before-write on the same edge, no internal bypass.
  always @(posedge clk) begin
    if (ram_read) ram_rdata <= ramMem[ram_raddr];
    if (wb_valid) begin
      ramTmp = ramMem[wb_addr];
      for (int j = 0; j < NT; j++)
        if (wb_tmask[j]) ramTmp[j*XL +: XL] = wb_data[j*XL +: XL];
      ramMem[wb_addr] <= ramTmp;
    end
  end

  task automatic compareVal(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cycle, act, exp);
    end
  endtask

  // Predicts this cycle's grant from occupancy and round-robin rules and queues the expected response.
  task automatic checkOutput();
    bit            expValid;
    bit            fire;
    int            expGrant;
    logic [N-1:0]  expReady;
    logic [DW-1:0] word;
    expT           e;
    expValid = !nxReset && expQ.size() > 0 && (expQ[0].cyc + 2 <= cycle);
    fire = expValid && nxRspReady;
    expGrant = -1;
    if (!nxReset && (expQ.size() - int'(fire)) < 2) begin
      for (int k = 0; k < N; k++) begin
        if (expGrant < 0 && nxValid[(rrPtr + k) % N]) expGrant = (rrPtr + k) % N;
      end
    end
    expReady = '0;
    if (expGrant >= 0) expReady[expGrant] = 1'b1;
    compareVal("req_ready", DW'(req_ready), DW'(expReady));
    compareVal("ram_read", DW'(ram_read), DW'(expGrant >= 0));
    if (expGrant >= 0) begin
      compareVal("ram_raddr", DW'(ram_raddr), DW'(nxAddr[expGrant]));
      word = ramMem[nxAddr[expGrant]];
      if (nxWbValid && nxWbAddr == nxAddr[expGrant])
        for (int j = 0; j < NT; j++)
          if (nxWbMask[j]) word[j*XL +: XL] = nxWbData[j*XL +: XL];
      e.idx = expGrant;
      e.tag = nxTag[expGrant];
      e.data = word;
      e.cyc = cycle;
      expQ.push_back(e);
      rrPtr = (expGrant + 1) % N;
    end
    if (nxReset) begin
      expQ.delete();
      rrPtr = 0;
    end
  endtask

  task automatic applyStimulus();
    @(negedge clk);
    cycle++;
    reset_n = !nxReset;
    req_valid = nxValid;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW] = nxAddr[i];
      req_tag[i*TW +: TW] = nxTag[i];
    end
    wb_valid = nxWbValid;
    wb_addr = nxWbAddr;
    wb_tmask = nxWbMask;
    wb_data = nxWbData;
    rsp_ready = nxRspReady;
    #1;
    checkOutput();
  endtask

  task automatic idleInputs();
    nxValid = '0;
    nxWbValid = 1'b0;
    nxReset = 1'b0;
  endtask

  task automatic runCycles(input int n);
    for (int c = 0; c < n; c++) applyStimulus();
  endtask

  // Monitor: checks response visibility every cycle and pops the scoreboard on each accepted response.
  initial begin
    expT e;
    bit  expValid;
    forever begin
      @(negedge clk);
      #2;
      expValid = reset_n && expQ.size() > 0 && (expQ[0].cyc + 2 <= cycle);
      compareVal("rsp_valid", DW'(rsp_valid), DW'(expValid));
      if (rsp_valid && rsp_ready) begin
        if (expQ.size() == 0) begin
          compareVal("unexpected_rsp", DW'(1), DW'(0));
        end else begin
          e = expQ.pop_front();
          compareVal("rsp_idx", DW'(rsp_idx), DW'(e.idx));
          compareVal("rsp_tag", DW'(rsp_tag), DW'(e.tag));
          compareVal("rsp_data", rsp_data, e.data);
        end
      end
    end
  end

  initial begin
    for (int a = 0; a < 256; a++)
      for (int j = 0; j < NT; j++) ramMem[a][j*XL +: XL] = $urandom;
    ramMem[8'h12] = {32'd4, 32'd3, 32'd2, 32'd1};
    for (int i = 0; i < N; i++) begin
      nxAddr[i] = AW'(i);
      nxTag[i] = TW'(i);
    end
    nxWbAddr = '0;
    nxWbMask = '0;
    nxWbData = '0;
    nxRspReady = 1'b1;
    idleInputs();

    nxReset = 1'b1;
    runCycles(3);
    idleInputs();

    // Single read latency from requester 2.
    nxValid = 4'b0100;
    nxAddr[2] = 8'h12;
    nxTag[2] = 4'd5;
    runCycles(1);
    idleInputs();
    runCycles(4);

    // Same-cycle bypass, then a write one cycle after the grant that must not merge.
    ramMem[8'h20] = {4{32'hAAAA_AAAA}};
    nxValid = 4'b0001;
    nxAddr[0] = 8'h20;
    nxWbValid = 1'b1;
    nxWbAddr = 8'h20;
    nxWbMask = 4'b0101;
    nxWbData = {4{32'hBBBB_BBBB}};
    runCycles(1);
    idleInputs();
    runCycles(3);
    ramMem[8'h20] = {4{32'hAAAA_AAAA}};
    nxValid = 4'b0001;
    runCycles(1);
    nxValid = '0;
    nxWbValid = 1'b1;
    runCycles(1);
    idleInputs();
    runCycles(3);

    // Round robin with all requesters valid from reset.
    nxReset = 1'b1;
    runCycles(1);
    idleInputs();
    for (int i = 0; i < N; i++) nxAddr[i] = AW'(8'h30 + i);
    nxValid = 4'b1111;
    runCycles(12);
    idleInputs();
    runCycles(3);

    // Backpressure: two grants then stall until the consumer returns.
    nxValid = 4'b0011;
    nxRspReady = 1'b0;
    runCycles(6);
    nxRspReady = 1'b1;
    runCycles(4);
    idleInputs();
    runCycles(3);

    // Reset with one entry queued and one in flight.
    nxValid = 4'b0001;
    nxRspReady = 1'b0;
    runCycles(2);
    nxValid = '0;
    nxReset = 1'b1;
    runCycles(1);
    nxReset = 1'b0;
    nxRspReady = 1'b1;
    nxValid = 4'b1010;
    runCycles(1);
    idleInputs();
    runCycles(3);

    // Full queue with simultaneous push and pop.
    nxValid = 4'b1111;
    nxRspReady = 1'b0;
    runCycles(4);
    nxRspReady = 1'b1;
    runCycles(8);
    idleInputs();
    runCycles(3);

    // Randomized traffic with writebacks, backpressure and occasional resets.
    for (int c = 0; c < 400; c++) begin
      nxValid = N'($urandom);
      for (int i = 0; i < N; i++) begin
        nxAddr[i] = AW'($urandom_range(0, 15));
        nxTag[i] = TW'($urandom);
      end
      nxWbValid = ($urandom_range(0, 1) == 1);
      nxWbAddr = AW'($urandom_range(0, 15));
      nxWbMask = NT'($urandom);
      for (int j = 0; j < NT; j++) nxWbData[j*XL +: XL] = $urandom;
      nxRspReady = ($urandom_range(0, 9) < 7);
      nxReset = ($urandom_range(0, 99) == 0);
      applyStimulus();
    end

    idleInputs();
    nxRspReady = 1'b1;
    for (int c = 0; c < 10 && expQ.size() > 0; c++) applyStimulus();
    runCycles(1);
    compareVal("drain_empty", DW'(expQ.size()), DW'(0));

    #5;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
